// File: rtl/symbol_slicer_pkg.sv
// Shared constants and state type for the symbol slicer.
// The correlator and the framing FSM both import this package.
package symbol_slicer_pkg;

    localparam int DATA_WIDTH               = 8;
    localparam int WAVELENGTH               = 16;
    localparam int AMPLITUDE                = 254;
    localparam int THRESHOLD                = 0;
    localparam int WAVES_PER_SYMBOL_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ALIGN,
        ST_INTEGRATE
    } slicer_state_e;

endpackage

// File: rtl/symbol_correlator.sv
// Centres each sample and multiplies it by the carrier reference sign,
// then integrates the products over one symbol.
module symbol_correlator
    import symbol_slicer_pkg::*;
#(
    parameter int CYCLES_PER_SYMBOL = WAVELENGTH * WAVES_PER_SYMBOL_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] signal,
    input  logic [15:0]           phase,
    input  logic [15:0]           ref_offset,
    input  logic                  integrate,
    output logic                  aligned_zero,
    output logic                  sym_done,
    output logic                  sym_bit
);

    localparam int CEN_W = DATA_WIDTH + 1;
    localparam int ACC_W = DATA_WIDTH + 1 + $clog2(CYCLES_PER_SYMBOL) + 1;
    localparam int CNT_W = $clog2(CYCLES_PER_SYMBOL) + 1;

    logic signed [CEN_W-1:0] centered_d, centered_q;
    logic        [15:0]      aligned_d, aligned_q;
    logic signed [ACC_W-1:0] acc_d, acc_q;
    logic signed [ACC_W-1:0] product, sum;
    logic        [CNT_W-1:0] count_d, count_q;
    logic        [17:0]      phase_ext;

    always_comb begin
        centered_d = signed'({1'b0, signal}) - signed'(CEN_W'(AMPLITUDE / 2));
        phase_ext  = {2'b00, phase} + 18'(WAVELENGTH) - {2'b00, ref_offset};
        aligned_d  = 16'(phase_ext % 18'(WAVELENGTH));

        product = (aligned_q < 16'(WAVELENGTH / 2)) ? ACC_W'(centered_q)
                                                     : -ACC_W'(centered_q);
        sum     = acc_q + product;

        aligned_zero = (aligned_q == '0);
        sym_done     = integrate && (count_q == CNT_W'(CYCLES_PER_SYMBOL - 1));
        sym_bit      = (sum >= ACC_W'(THRESHOLD));

        // Clearing on the final sample lets the next symbol start without a gap.
        acc_d   = acc_q;
        count_d = count_q;
        if (!integrate || sym_done) begin
            acc_d   = '0;
            count_d = '0;
        end else begin
            acc_d   = sum;
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            centered_q <= '0;
            aligned_q  <= '0;
            acc_q      <= '0;
            count_q    <= '0;
        end else begin
            centered_q <= centered_d;
            aligned_q  <= aligned_d;
            acc_q      <= acc_d;
            count_q    <= count_d;
        end
    end

endmodule

// File: rtl/symbol_slicer.sv
// Framing FSM and output handshake around the symbol correlator; turns a
// carrier-modulated sample stream into decided bits.
module symbol_slicer
    import symbol_slicer_pkg::*;
#(
    parameter int WAVES_PER_SYMBOL  = WAVES_PER_SYMBOL_DEFAULT,
    parameter int CYCLES_PER_SYMBOL = WAVELENGTH * WAVES_PER_SYMBOL
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] signal,
    input  logic [15:0]           phase,
    input  logic [15:0]           offset,
    input  logic                  offset_valid,
    output logic                  bit_out,
    output logic                  bit_valid,
    input  logic                  bit_ready,
    output logic                  locked,
    output logic                  overrun
);

    slicer_state_e state_d, state_q;
    logic [15:0]   offset_d, offset_q;
    logic          bit_out_d, bit_out_q;
    logic          bit_valid_d, bit_valid_q;
    logic          locked_d, locked_q;
    logic          overrun_d, overrun_q;
    logic          integrate;
    logic          aligned_zero;
    logic          sym_done;
    logic          sym_bit;

    assign integrate = offset_valid &&
                       ((state_q == ST_INTEGRATE) ||
                        ((state_q == ST_ALIGN) && aligned_zero));

    symbol_correlator #(
        .CYCLES_PER_SYMBOL(CYCLES_PER_SYMBOL)
    ) u_correlator (
        .clk         (clk),
        .rst_n       (rst_n),
        .signal      (signal),
        .phase       (phase),
        .ref_offset  (offset_q),
        .integrate   (integrate),
        .aligned_zero(aligned_zero),
        .sym_done    (sym_done),
        .sym_bit     (sym_bit)
    );

    always_comb begin
        state_d     = state_q;
        offset_d    = offset_q;
        bit_out_d   = bit_out_q;
        bit_valid_d = bit_valid_q;
        overrun_d   = overrun_q;

        case (state_q)
            ST_IDLE: begin
                if (offset_valid) begin
                    state_d  = ST_ALIGN;
                    offset_d = offset;
                end
            end
            ST_ALIGN: begin
                if (!offset_valid) begin
                    state_d = ST_IDLE;
                end else if (aligned_zero) begin
                    state_d = ST_INTEGRATE;
                end
            end
            ST_INTEGRATE: begin
                if (!offset_valid) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A fresh decision wins over a same-cycle consume; only an unread bit counts as overrun.
        if (bit_valid_q && bit_ready) begin
            bit_valid_d = 1'b0;
        end
        if (sym_done) begin
            if (bit_valid_q && !bit_ready) begin
                overrun_d = 1'b1;
            end
            bit_out_d   = sym_bit;
            bit_valid_d = 1'b1;
        end

        locked_d = (state_d == ST_INTEGRATE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            offset_q    <= '0;
            bit_out_q   <= 1'b0;
            bit_valid_q <= 1'b0;
            locked_q    <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            offset_q    <= offset_d;
            bit_out_q   <= bit_out_d;
            bit_valid_q <= bit_valid_d;
            locked_q    <= locked_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bit_out   = bit_out_q;
    assign bit_valid = bit_valid_q;
    assign locked    = locked_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_symbol_slicer.sv
// Self-checking bench for symbol_slicer: directed symbol table, handshake,
// drop and reset sequences, then random traffic against a reference model.
module tb_symbol_slicer;
    import symbol_slicer_pkg::*;

    localparam int WL  = 16;
    localparam int CPS = 32;

    typedef struct {
        int kind;
        bit exp_bit;
    } sym_vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  signal;
    logic [15:0] phase;
    logic [15:0] offset;
    logic        offset_valid;
    logic        bit_ready;
    logic        bit_out;
    logic        bit_valid;
    logic        locked;
    logic        overrun;

    int errors = 0;
    int checks = 0;
    int phase_cnt = 0;
    int cur_off = 4;
    int sine_tab[16] = '{0, 49, 90, 117, 127, 117, 90, 49,
                         0, -49, -90, -117, -127, -117, -90, -49};
    sym_vec_t tab[7];

    // Reference model state: framing mode, latched offset, the sample seen on
    // the previous edge, and the products gathered for the current symbol.
    int m_state;
    int m_off;
    int p_aligned;
    int p_centered;
    int prods[$];
    int m_new_al;
    int m_new_cen;
    int m_prod;
    int m_total;
    bit m_done;
    bit m_dec;
    bit m_was_valid;
    bit e_valid;
    bit e_bit;
    bit e_over;
    bit e_locked;

    always #5 clk = ~clk;

    symbol_slicer #(
        .WAVES_PER_SYMBOL(2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .signal      (signal),
        .phase       (phase),
        .offset      (offset),
        .offset_valid(offset_valid),
        .bit_out     (bit_out),
        .bit_valid   (bit_valid),
        .bit_ready   (bit_ready),
        .locked      (locked),
        .overrun     (overrun)
    );

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state    = 0;
            m_off      = 0;
            p_aligned  = 0;
            p_centered = 0;
            prods.delete();
            e_valid    = 0;
            e_bit      = 0;
            e_over     = 0;
            e_locked   = 0;
        end else begin
            m_new_al  = (int'(phase) + WL - m_off) % WL;
            m_new_cen = int'(signal) - AMPLITUDE / 2;
            m_prod    = (p_aligned < WL / 2) ? p_centered : -p_centered;
            m_done    = 0;
            m_dec     = 0;
            case (m_state)
                0: if (offset_valid) begin
                    m_off   = int'(offset);
                    m_state = 1;
                end
                1: if (!offset_valid) begin
                    m_state = 0;
                end else if (p_aligned == 0) begin
                    prods   = {m_prod};
                    m_state = 2;
                end
                default: if (!offset_valid) begin
                    prods.delete();
                    m_state = 0;
                end else begin
                    prods.push_back(m_prod);
                    if (prods.size() == CPS) begin
                        m_total = 0;
                        foreach (prods[i]) m_total += prods[i];
                        m_done = 1;
                        m_dec  = (m_total >= 0);
                        prods.delete();
                    end
                end
            endcase
            m_was_valid = e_valid;
            if (e_valid && bit_ready) e_valid = 0;
            if (m_done) begin
                if (m_was_valid && !bit_ready) e_over = 1;
                e_valid = 1;
                e_bit   = m_dec;
            end
            e_locked   = (m_state == 2);
            p_aligned  = m_new_al;
            p_centered = m_new_cen;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [7:0] sampleFor(input int kind, input int al);
        int v;
        case (kind)
            0:       v = 127 + sine_tab[al];
            1:       v = 127 - sine_tab[al];
            3:       v = int'($urandom_range(0, 255));
            4:       v = 127 - sine_tab[al] / 2;
            5:       v = 127 + sine_tab[al] / 2;
            default: v = 127;
        endcase
        return 8'(v);
    endfunction

    // Presents one sample, clocks it in, and compares all outputs with the model.
    task automatic applyStimulus(input int kind, input bit ov, input bit rdy);
        int al;
        al           = (phase_cnt + WL - cur_off) % WL;
        signal       = sampleFor(kind, al);
        phase        = 16'(phase_cnt);
        offset       = 16'(cur_off);
        offset_valid = ov;
        bit_ready    = rdy;
        phase_cnt    = (phase_cnt + 1) % WL;
        @(posedge clk);
        @(negedge clk);
        checkOutput("model_bit_valid", bit_valid, e_valid);
        checkOutput("model_bit_out", bit_out, e_bit);
        checkOutput("model_locked", locked, e_locked);
        checkOutput("model_overrun", overrun, e_over);
    endtask

    task automatic runSamples(input int kind, input bit ov, input bit rdy, input int n);
        for (int k = 0; k < n; k++) applyStimulus(kind, ov, rdy);
    endtask

    // Leaves the slicer in ALIGN with the aligned-zero sample presented next.
    task automatic doAlign(input bit rdy);
        while (phase_cnt != (cur_off + 1) % WL) applyStimulus(2, 0, rdy);
        do applyStimulus(2, 1, rdy); while (phase_cnt != cur_off);
    endtask

    initial begin
        int ov_r;
        int kind_r;
        tab = '{'{0, 1'b1}, '{1, 1'b0}, '{0, 1'b1}, '{2, 1'b1},
                '{4, 1'b0}, '{5, 1'b1}, '{1, 1'b0}};
        rst_n = 1'b0; signal = '0; phase = '0; offset = 16'd4;
        offset_valid = 1'b0; bit_ready = 1'b0;
        #1;
        checkOutput("reset_bit_out", bit_out, 0);
        checkOutput("reset_bit_valid", bit_valid, 0);
        checkOutput("reset_locked", locked, 0);
        checkOutput("reset_overrun", overrun, 0);
        runSamples(2, 0, 1, 2);
        rst_n = 1'b1;

        doAlign(1);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(tab[i].kind, 1, 1);
            if (i == 0) begin
                checkOutput("align_no_bit", bit_valid, 0);
                checkOutput("align_locked_low", locked, 0);
            end else begin
                checkOutput("table_bit_valid", bit_valid, 1);
                checkOutput("table_bit_out", bit_out, 32'(tab[i-1].exp_bit));
            end
            applyStimulus(tab[i].kind, 1, 1);
            checkOutput("table_valid_one_cycle", bit_valid, 0);
            checkOutput("table_locked", locked, 1);
            runSamples(tab[i].kind, 1, 1, CPS - 2);
        end

        applyStimulus(0, 1, 1);
        checkOutput("table_last_valid", bit_valid, 1);
        checkOutput("table_last_bit", bit_out, 32'(tab[6].exp_bit));
        runSamples(0, 1, 0, CPS - 1);
        applyStimulus(1, 1, 1);
        checkOutput("coincident_valid", bit_valid, 1);
        checkOutput("coincident_bit", bit_out, 1);
        checkOutput("coincident_overrun", overrun, 0);
        runSamples(1, 1, 0, CPS - 1);
        applyStimulus(0, 1, 0);
        checkOutput("overwrite_bit", bit_out, 0);
        checkOutput("overwrite_overrun", overrun, 1);
        runSamples(0, 1, 0, CPS - 1);
        applyStimulus(1, 1, 1);
        checkOutput("sticky_overrun", overrun, 1);
        checkOutput("sticky_valid", bit_valid, 1);
        checkOutput("sticky_bit", bit_out, 1);

        runSamples(1, 1, 0, 9);
        applyStimulus(1, 0, 0);
        checkOutput("drop_locked", locked, 0);
        checkOutput("drop_valid_retained", bit_valid, 1);
        runSamples(1, 0, 0, 40);
        checkOutput("drop_no_new_bit", bit_out, 1);
        checkOutput("drop_valid_still", bit_valid, 1);
        applyStimulus(2, 0, 1);
        checkOutput("drop_consumed", bit_valid, 0);

        doAlign(1);
        checkOutput("realign_wait", locked, 0);
        applyStimulus(1, 1, 1);
        checkOutput("realign_first_sample", locked, 0);
        applyStimulus(1, 1, 1);
        checkOutput("realign_locked", locked, 1);
        runSamples(1, 1, 1, CPS - 2);
        applyStimulus(0, 1, 1);
        checkOutput("realign_bit", bit_out, 0);
        checkOutput("realign_valid", bit_valid, 1);
        runSamples(0, 1, 0, 15);

        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_bit_out", bit_out, 0);
        checkOutput("async_reset_bit_valid", bit_valid, 0);
        checkOutput("async_reset_locked", locked, 0);
        checkOutput("async_reset_overrun", overrun, 0);
        @(negedge clk);
        runSamples(2, 0, 1, 2);
        rst_n = 1'b1;
        doAlign(1);
        runSamples(0, 1, 1, CPS);
        applyStimulus(2, 1, 1);
        checkOutput("post_reset_valid", bit_valid, 1);
        checkOutput("post_reset_bit", bit_out, 1);
        checkOutput("post_reset_overrun", overrun, 0);

        ov_r   = 1;
        kind_r = 3;
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 99) < 1) ov_r = 1 - ov_r;
            if (ov_r == 0 && $urandom_range(0, 3) == 0) cur_off = int'($urandom_range(0, 15));
            if (c % CPS == 0) kind_r = int'($urandom_range(0, 3));
            applyStimulus(kind_r, ov_r[0], bit'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/symbol_slicer.md
SYMBOL_SLICER -- requirements
Module: symbol_slicer

Interface
REQ-001 Parameter WAVES_PER_SYMBOL, default 4, carrier wavelengths per transmitted bit.
REQ-002 Parameter CYCLES_PER_SYMBOL, default WAVELENGTH*WAVES_PER_SYMBOL, integration length in clock cycles.
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 rst_n  input  1  reset; one clock, reset is asynchronous and active-low.
REQ-005 signal  input  DATA_WIDTH  unsigned received sample, midscale AMPLITUDE/2.
REQ-006 phase  input  16  free-running demod phase counter, 0..WAVELENGTH-1.
REQ-007 offset  input  16  carrier offset from peak detector, 0..WAVELENGTH-1.
REQ-008 offset_valid  input  1  peak detector ready; offset stable while high.
REQ-009 bit_out  output  1  decided bit.
REQ-010 bit_valid  output  1  bit_out holds an unconsumed bit.
REQ-011 bit_ready  input  1  consumer accepts bit when bit_valid&&bit_ready.
REQ-012 locked  output  1  high in ALIGN-complete/INTEGRATE operation.
REQ-013 overrun  output  1  sticky: a decided bit overwrote an unconsumed one.

Function
REQ-014 Stage 1 (registered, 1 cycle): centered = signed(signal) - AMPLITUDE/2, width DATA_WIDTH+1; aligned = (phase + WAVELENGTH - offset_q) % WAVELENGTH.
REQ-015 offset_q latched on the cycle offset_valid is first seen high in IDLE; not re-sampled until return to IDLE.
REQ-016 Reference sign: +1 when aligned < WAVELENGTH/2, else -1.
REQ-017 Accumulator signed, width DATA_WIDTH+1+clog2(CYCLES_PER_SYMBOL)+1; never saturates or wraps within a symbol.
REQ-018 States IDLE, ALIGN, INTEGRATE.
REQ-019 IDLE -> ALIGN when offset_valid=1; locked=0.
REQ-020 ALIGN -> INTEGRATE when stage-1 aligned==0; that sample is the first of the symbol; acc loaded with its signed product.
REQ-021 INTEGRATE: acc += ref*centered each cycle; sample counter counts 1..CYCLES_PER_SYMBOL.
REQ-022 On the CYCLES_PER_SYMBOL-th sample: bit_out <= (final acc >= 0), bit_valid <= 1, acc and counter restart with the next sample; no dead cycles between symbols.
REQ-023 Latency: bit_valid rises 2 clk after the last sample of a symbol is presented on signal.
REQ-024 Tie acc==0 decides 1.
REQ-025 Handshake: bit_valid clears on the edge where bit_valid&&bit_ready, unless a new bit decides the same cycle (then bit_valid stays 1, new bit_out, no overrun).
REQ-026 New decision while bit_valid=1 and bit_ready=0: overwrite bit_out, set overrun; overrun clears only by reset.
REQ-027 offset_valid falls in ALIGN or INTEGRATE: next state IDLE, partial acc discarded, no bit emitted, pending bit_valid retained.
REQ-028 locked=1 exactly in INTEGRATE.

Reset
REQ-029 rst_n low asynchronously forces IDLE, acc=0, counter=0, offset_q=0, stage-1 registers 0, bit_out=0, bit_valid=0, locked=0, overrun=0.
REQ-030 Reset mid-symbol discards the partial symbol; first bit after release requires full re-alignment.

Structure
REQ-031 WAVES_PER_SYMBOL default and the state enum belong in the shared parameters package beside DATA_WIDTH, WAVELENGTH, AMPLITUDE, THRESHOLD.
REQ-032 One sub-module natural: symbol_correlator (stage-1 centering, sign, accumulator, counter); FSM and handshake stay in symbol_slicer.

Verification (bench: DATA_WIDTH=8, WAVELENGTH=16, AMPLITUDE=254, WAVES_PER_SYMBOL=2)
REQ-033 offset=4, offset_valid=1, in-phase sine for 32 cycles from aligned 0, bit_ready=1 -> bit_out=1, bit_valid one cycle, 2 clk after last sample.
REQ-034 Same, inverted sine -> bit_out=0; alternating symbols 1,0,1 -> three bits 32 cycles apart, no gaps.
REQ-035 Constant signal=127 for one symbol -> acc=0, bit_out=1.
REQ-036 bit_ready=0 across two symbols -> second bit overwrites, overrun=1 sticky; bit_ready=1 coincident with decision -> bit_valid stays 1, overrun unchanged.
REQ-037 offset_valid dropped at cycle 10 of symbol -> IDLE, locked=0, no bit; reassert -> ALIGN waits for aligned==0.
REQ-038 rst_n pulsed low mid-symbol, asynchronous to clk -> all outputs 0 immediately, restart from IDLE.
